// File: rtl/vga_pkg.sv
// Shared 640x480@60 raster constants, coordinate width and controller state type.
package vga_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned FRAME_CNT_W = 16;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FRONT  = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BACK   = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FRONT  = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BACK   = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // 640x480 uses negative sync pulses
  localparam logic VGA_SYNC_POL = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vga_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-low clear.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], d_i};
    end
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: counters, sync/de decode and strobes, held idle until PLL lock.
// Define VGA_TIMING_FRAMECNT_EN to add the frame_cnt output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FRONT  = VGA_H_FRONT,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BACK   = VGA_H_BACK,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FRONT  = VGA_V_FRONT,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BACK   = VGA_V_BACK,
  parameter logic        SYNC_POL = VGA_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_locked,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic               running
`ifdef VGA_TIMING_FRAMECNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_ACTIVE + H_FRONT;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FRONT;
  localparam int unsigned VS_END   = VS_START + V_SYNC;

  logic lock_s;

  sync2 u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pll_locked),
    .q_o  (lock_s)
  );

  vga_state_e         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [COORD_W-1:0] x_nxt, y_nxt;
  logic               advance;
  logic               hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
  logic               line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic               running_q, running_d;
`ifdef VGA_TIMING_FRAMECNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      running_q     <= 1'b0;
`ifdef VGA_TIMING_FRAMECNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      running_q     <= running_d;
`ifdef VGA_TIMING_FRAMECNT_EN
      frame_cnt_q   <= frame_cnt_d;
`endif
    end
  end

  // Next raster position and its decode are registered together so all outputs stay aligned.
  always_comb begin
    state_d       = state_q;
    advance       = 1'b0;
    x_nxt         = '0;
    y_nxt         = '0;
    x_d           = '0;
    y_d           = '0;
    hsync_d       = ~SYNC_POL;
    vsync_d       = ~SYNC_POL;
    de_d          = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    running_d     = 1'b0;
`ifdef VGA_TIMING_FRAMECNT_EN
    frame_cnt_d   = '0;
`endif

    case (state_q)
      IDLE: begin
        if (lock_s) begin
          state_d = RUN;
          advance = 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d = IDLE;
        end else begin
          advance = 1'b1;
          if (x_q == COORD_W'(H_TOTAL - 1)) begin
            x_nxt = '0;
            y_nxt = (y_q == COORD_W'(V_TOTAL - 1)) ? '0 : y_q + COORD_W'(1);
          end else begin
            x_nxt = x_q + COORD_W'(1);
            y_nxt = y_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      x_d           = x_nxt;
      y_d           = y_nxt;
      de_d          = (x_nxt < COORD_W'(H_ACTIVE)) && (y_nxt < COORD_W'(V_ACTIVE));
      hsync_d       = ((x_nxt >= COORD_W'(HS_START)) && (x_nxt < COORD_W'(HS_END))) ?
                      SYNC_POL : ~SYNC_POL;
      vsync_d       = ((y_nxt >= COORD_W'(VS_START)) && (y_nxt < COORD_W'(VS_END))) ?
                      SYNC_POL : ~SYNC_POL;
      line_start_d  = (x_nxt == '0);
      frame_start_d = (x_nxt == '0) && (y_nxt == '0);
      running_d     = 1'b1;
`ifdef VGA_TIMING_FRAMECNT_EN
      // The first frame after entering RUN reads 0; later frame starts advance the count.
      if (state_q == RUN) begin
        frame_cnt_d = frame_start_d ? frame_cnt_q + FRAME_CNT_W'(1) : frame_cnt_q;
      end
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign running     = running_q;
`ifdef VGA_TIMING_FRAMECNT_EN
  assign frame_cnt   = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a full 640x480 instance plus a reduced-raster instance for frame-level behaviour.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic pll_locked;

  always #5 clk = ~clk;

  logic       f_hs, f_vs, f_de, f_ls, f_fs, f_run;
  logic [9:0] f_x, f_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs, s_run;
  logic [9:0] s_x, s_y;
  logic [15:0] f_fc, s_fc;

  vga_timing_gen u_full (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(f_hs), .vsync(f_vs), .de(f_de), .x(f_x), .y(f_y),
    .line_start(f_ls), .frame_start(f_fs), .running(f_run)
`ifdef VGA_TIMING_FRAMECNT_EN
    , .frame_cnt(f_fc)
`endif
  );

  // Small raster: H 8/2/3/3 (total 16, hsync x 10..12), V 6/2/2/2 (total 12, vsync y 8..9).
  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(s_hs), .vsync(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs), .running(s_run)
`ifdef VGA_TIMING_FRAMECNT_EN
    , .frame_cnt(s_fc)
`endif
  );

`ifndef VGA_TIMING_FRAMECNT_EN
  assign f_fc = 16'h0;
  assign s_fc = 16'h0;
`endif

  typedef struct {
    int          cyc;
    int          inst;
    string       nm;
    logic [41:0] exp;
  } item_t;

  typedef struct {
    int    at;
    int    idx;
    int    exp;
    string nm;
  } stat_t;

  item_t sb_q[$];
  stat_t st_q[$];
  int    cyc       = 0;
  int    stat_base = -1;
  int    cnt[9]    = '{default: 0};
  int    checks    = 0;
  int    errors    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string fmt(input logic [41:0] v);
    return $sformatf("x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b run=%b fc=%0d",
                     v[41:32], v[31:22], v[21], v[20], v[19], v[18], v[17], v[16], v[15:0]);
  endfunction

  function automatic void push(input int c, input int inst, input string nm,
                               input int xv, input int yv, input bit hs, input bit vs,
                               input bit de, input bit ls, input bit fs, input bit run,
                               input int fc);
    item_t it;
    logic [15:0] fcv;
    fcv = 16'(fc);
`ifndef VGA_TIMING_FRAMECNT_EN
    fcv = 16'h0;
`endif
    it.cyc  = c;
    it.inst = inst;
    it.nm   = nm;
    it.exp  = {10'(xv), 10'(yv), hs, vs, de, ls, fs, run, fcv};
    sb_q.push_back(it);
  endfunction

  function automatic void push_idle(input int c, input string nm);
    push(c, 0, {nm, "_full"},  0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    push(c, 1, {nm, "_small"}, 0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
  endfunction

  function automatic void push_stat(input int at, input int idx, input int exp, input string nm);
    stat_t s;
    s.at  = at;
    s.idx = idx;
    s.exp = exp;
    s.nm  = nm;
    st_q.push_back(s);
  endfunction

  // Monitor: accumulate window statistics, then retire every expectation due this cycle.
  always @(negedge clk) begin : monitor
    logic [41:0] act;
    int k;
    if (stat_base >= 0) begin
      k = cyc - stat_base;
      if (k >= 0 && k < 800) begin
        cnt[0] = cnt[0] + (f_de ? 1 : 0);
        cnt[1] = cnt[1] + (f_hs ? 0 : 1);
        cnt[2] = cnt[2] + (f_ls ? 1 : 0);
        cnt[3] = cnt[3] + (f_fs ? 1 : 0);
      end
      if (k >= 0 && k < 384) begin
        cnt[4] = cnt[4] + (s_de ? 1 : 0);
        cnt[5] = cnt[5] + (s_hs ? 0 : 1);
        cnt[6] = cnt[6] + (s_vs ? 0 : 1);
        cnt[7] = cnt[7] + (s_ls ? 1 : 0);
        cnt[8] = cnt[8] + (s_fs ? 1 : 0);
      end
    end
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cyc) begin
        if (sb_q[i].inst == 0)
          act = {f_x, f_y, f_hs, f_vs, f_de, f_ls, f_fs, f_run, f_fc};
        else
          act = {s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs, s_run, s_fc};
        checks++;
        if (sb_q[i].cyc < cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not checked in time", sb_q[i].nm, sb_q[i].cyc);
        end else if (act !== sb_q[i].exp) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %s, want %s", sb_q[i].nm, cyc, fmt(act), fmt(sb_q[i].exp));
        end
        sb_q.delete(i);
      end
    end
    for (int i = st_q.size() - 1; i >= 0; i--) begin
      if (st_q[i].at <= cyc) begin
        checks++;
        if (st_q[i].at < cyc || cnt[st_q[i].idx] != st_q[i].exp) begin
          errors++;
          $display("FAIL %s: got %0d, want %0d", st_q[i].nm, cnt[st_q[i].idx], st_q[i].exp);
        end
        st_q.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
    end
  endtask

  int r, p, b, c;

  initial begin
    rst_n      = 1'b0;
    pll_locked = 1'b0;
    push_idle(1, "in_reset");
    push_idle(2, "in_reset");
    wait_cyc(3);
    rst_n = 1'b1;
    r = cyc;
    for (int i = 0; i <= 100; i++) push_idle(r + i, "unlocked");

    wait_cyc(r + 100);
    p = cyc;
    pll_locked = 1'b1;
    b = p + 3;
    push_idle(p + 1, "lock_lat1");
    push_idle(p + 2, "lock_lat2");

    push(b + 0,    0, "f_first",   0,   0, 1, 1, 1, 1, 1, 1, 0);
    push(b + 1,    0, "f_second",  1,   0, 1, 1, 1, 0, 0, 1, 0);
    push(b + 639,  0, "f_de_last", 639, 0, 1, 1, 1, 0, 0, 1, 0);
    push(b + 640,  0, "f_de_off",  640, 0, 1, 1, 0, 0, 0, 1, 0);
    push(b + 655,  0, "f_hs_pre",  655, 0, 1, 1, 0, 0, 0, 1, 0);
    push(b + 656,  0, "f_hs_on",   656, 0, 0, 1, 0, 0, 0, 1, 0);
    push(b + 751,  0, "f_hs_end",  751, 0, 0, 1, 0, 0, 0, 1, 0);
    push(b + 752,  0, "f_hs_off",  752, 0, 1, 1, 0, 0, 0, 1, 0);
    push(b + 799,  0, "f_x_max",   799, 0, 1, 1, 0, 0, 0, 1, 0);
    push(b + 800,  0, "f_line1",   0,   1, 1, 1, 1, 1, 0, 1, 0);
    push(b + 1100, 0, "f_predrop", 300, 1, 1, 1, 1, 0, 0, 1, 0);
    push(b + 1101, 0, "f_drop1",   301, 1, 1, 1, 1, 0, 0, 1, 0);
    push(b + 1102, 0, "f_drop2",   302, 1, 1, 1, 1, 0, 0, 1, 0);

    push(b + 0,    1, "s_first",   0,  0,  1, 1, 1, 1, 1, 1, 0);
    push(b + 7,    1, "s_de_last", 7,  0,  1, 1, 1, 0, 0, 1, 0);
    push(b + 8,    1, "s_de_off",  8,  0,  1, 1, 0, 0, 0, 1, 0);
    push(b + 10,   1, "s_hs_on",   10, 0,  0, 1, 0, 0, 0, 1, 0);
    push(b + 12,   1, "s_hs_end",  12, 0,  0, 1, 0, 0, 0, 1, 0);
    push(b + 13,   1, "s_hs_off",  13, 0,  1, 1, 0, 0, 0, 1, 0);
    push(b + 15,   1, "s_x_max",   15, 0,  1, 1, 0, 0, 0, 1, 0);
    push(b + 16,   1, "s_line1",   0,  1,  1, 1, 1, 1, 0, 1, 0);
    push(b + 87,   1, "s_y5",      7,  5,  1, 1, 1, 0, 0, 1, 0);
    push(b + 96,   1, "s_y6",      0,  6,  1, 1, 0, 1, 0, 1, 0);
    push(b + 127,  1, "s_vs_pre",  15, 7,  1, 1, 0, 0, 0, 1, 0);
    push(b + 128,  1, "s_vs_on",   0,  8,  1, 0, 0, 1, 0, 1, 0);
    push(b + 138,  1, "s_hs_vs",   10, 8,  0, 0, 0, 0, 0, 1, 0);
    push(b + 159,  1, "s_vs_end",  15, 9,  1, 0, 0, 0, 0, 1, 0);
    push(b + 160,  1, "s_vs_off",  0,  10, 1, 1, 0, 1, 0, 1, 0);
    push(b + 191,  1, "s_frm_end", 15, 11, 1, 1, 0, 0, 0, 1, 0);
    push(b + 192,  1, "s_frame1",  0,  0,  1, 1, 1, 1, 1, 1, 1);
    push(b + 384,  1, "s_frame2",  0,  0,  1, 1, 1, 1, 1, 1, 2);
    push(b + 1100, 1, "s_predrop", 12, 8,  0, 0, 0, 0, 0, 1, 5);
    push(b + 1102, 1, "s_drop2",   14, 8,  1, 0, 0, 0, 0, 1, 5);

    stat_base = b;
    push_stat(b + 800, 0, 640, "f_de_per_line");
    push_stat(b + 800, 1, 96,  "f_hsync_per_line");
    push_stat(b + 800, 2, 1,   "f_line_start_per_800");
    push_stat(b + 800, 3, 1,   "f_frame_start_per_800");
    push_stat(b + 384, 4, 96,  "s_de_two_frames");
    push_stat(b + 384, 5, 72,  "s_hsync_two_frames");
    push_stat(b + 384, 6, 64,  "s_vsync_two_frames");
    push_stat(b + 384, 7, 24,  "s_line_start_two_frames");
    push_stat(b + 384, 8, 2,   "s_frame_start_two_frames");

    // Loss of lock mid-line, then relock from (0,0)
    wait_cyc(b + 1100);
    pll_locked = 1'b0;
    for (int i = 1103; i <= 1112; i++) push_idle(b + i, "unlocked_again");
    wait_cyc(b + 1110);
    pll_locked = 1'b1;
    push(b + 1113, 0, "f_relock",   0, 0, 1, 1, 1, 1, 1, 1, 0);
    push(b + 1114, 0, "f_relock1",  1, 0, 1, 1, 1, 0, 0, 1, 0);
    push(b + 1119, 0, "f_prerst",   6, 0, 1, 1, 1, 0, 0, 1, 0);
    push(b + 1113, 1, "s_relock",   0, 0, 1, 1, 1, 1, 1, 1, 0);
    push(b + 1114, 1, "s_relock1",  1, 0, 1, 1, 1, 0, 0, 1, 0);
    push(b + 1119, 1, "s_prerst",   6, 0, 1, 1, 1, 0, 0, 1, 0);

    // Reset asserted between clock edges must clear outputs before the next edge
    wait_cyc(b + 1120);
    push_idle(cyc, "async_reset");
    rst_n = 1'b0;
    wait_cyc(b + 1123);
    rst_n = 1'b1;
    c = cyc;
    push_idle(c,     "post_reset0");
    push_idle(c + 1, "post_reset1");
    push_idle(c + 2, "post_reset2");
    push(c + 3, 0, "f_restart",  0, 0, 1, 1, 1, 1, 1, 1, 0);
    push(c + 4, 0, "f_restart1", 1, 0, 1, 1, 1, 0, 0, 1, 0);
    push(c + 3, 1, "s_restart",  0, 0, 1, 1, 1, 1, 1, 1, 0);
    push(c + 4, 1, "s_restart1", 1, 0, 1, 1, 1, 0, 0, 1, 0);

    wait_cyc(c + 8);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Raster timing generator for 640x480@60 Hz VGA output.
- Runs on the 25.2 MHz pixel clock from the pixel PLL and consumes that PLL's lock indicator.
- Produces hsync/vsync, data-enable, pixel coordinates and frame/line strobes for the framebuffer scan-out stage.
- Holds the raster idle until the PLL is locked, and restarts cleanly from (0,0) after a loss of lock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks); H_TOTAL = sum = 800
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines); V_TOTAL = sum = 525
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low, as 640x480 requires)

Ports:
- clk  in  1  pixel clock, 25.2 MHz
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock indicator; asynchronous to clk, synchronised internally
- hsync  out  1  horizontal sync, polarity set by SYNC_POL
- vsync  out  1  vertical sync, polarity set by SYNC_POL
- de  out  1  high while (x,y) is inside the active area
- x  out  10  horizontal counter, 0..H_TOTAL-1
- y  out  10  vertical counter, 0..V_TOTAL-1
- line_start  out  1  one-cycle pulse when x==0 in RUN
- frame_start  out  1  one-cycle pulse when x==0 and y==0 in RUN
- running  out  1  high in RUN state

Behaviour:
- Reset (rst_n low, asynchronous) sets the following:
  - state IDLE, x=0, y=0, de=0, line_start=0, frame_start=0, running=0.
  - hsync and vsync at their inactive level, ~SYNC_POL.
  - both lock synchroniser flops cleared.
- Lock synchroniser: pll_locked passes through 2 flops to give lock_s.
- State machine:
  - IDLE -> RUN on the first edge where lock_s=1.
  - RUN -> IDLE on the edge after lock_s=0, from any raster position.
  - In IDLE, all outputs are held at their reset values.
- Output timing: all outputs are registered and mutually aligned.
  - In the cycle where x/y show a value, hsync/vsync/de/strobes are the decode of that same (x,y).
  - First RUN cycle shows x=0, y=0, frame_start=1, line_start=1, de=1.
  - Latency from the pll_locked rising edge to that first RUN cycle is 3 clk edges: 2 synchroniser edges plus the state transition.
- Counting:
  - x increments every RUN cycle; at x==H_TOTAL-1, x wraps to 0 and y increments.
  - At x==H_TOTAL-1 and y==V_TOTAL-1, both wrap to 0.
  - No other wrap exists; values at or above the totals are unreachable.
- Decode (comparisons are unsigned, on 10-bit values):
  - de = (x < H_ACTIVE) && (y < V_ACTIVE)
  - hsync active when H_ACTIVE+H_FRONT <= x < H_ACTIVE+H_FRONT+H_SYNC, i.e. x 656..751
  - vsync active when V_ACTIVE+V_FRONT <= y < V_ACTIVE+V_FRONT+V_SYNC, i.e. y 490..491, across entire lines
- Loss of lock mid-frame:
  - The next edge forces IDLE values: counters to 0, syncs inactive, de=0.
  - A later relock restarts at (0,0) with frame_start. Partial frames are never resumed.
- pll_locked glitches shorter than 1 clk may be missed; no minimum-width filtering is required.

Optional Feature:
- Macro: VGA_TIMING_FRAMECNT_EN.
- Defined:
  - Adds output frame_cnt[15:0], reset to 0.
  - Increments on each frame_start after the first frame following entry to RUN; the first frame after lock reads 0.
  - Wraps 0xFFFF -> 0. Cleared on entry to IDLE.
- Undefined: the port and its logic are absent.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480 timing constants and derived H_TOTAL/V_TOTAL;
  - the coordinate width localparam (10);
  - the state enum {IDLE, RUN}.
- Sub-module sync2: generic 2-flop synchroniser with async active-low clear, used for pll_locked.

Test Plan:
- Reset, then hold pll_locked=0 for 100 cycles -> running=0, x=y=0, hsync=vsync=1, de=0 throughout.
- Raise pll_locked -> third edge after it shows running=1, x=0, y=0, frame_start=1, de=1; next cycle x=1, frame_start=0.
- Run one full line -> de high exactly 640 cycles; hsync low exactly at x=656..751 (96 cycles); line_start period 800.
- Run two full frames -> frame_start period 420000 cycles; vsync low for exactly 1600 cycles starting at y=490, x=0; de low for all y>=480.
- Drop pll_locked at x=300, y=200 -> within 3 edges x=y=0, running=0, syncs inactive; relock -> frame_start at (0,0), and frame_cnt=0 if enabled.
- With VGA_TIMING_FRAMECNT_EN defined, run 3 frames -> frame_cnt reads 0,1,2; assert rst_n low mid-line -> all outputs return to reset values immediately (asynchronously).
